// File: rtl/credit_pkg.sv
// Shared types and defaults for the credit flow-control sender side.
//   CREDIT_MAX   : default maximum credit count (downstream buffer depth)
//   credit_t     : credit count type able to hold 0..CREDIT_MAX
//   err_flags_t  : sticky protocol error flags {overflow, ret_zero}
package credit_pkg;
  localparam int CREDIT_MAX       = 8;
  localparam int CREDIT_W_DEFAULT = $clog2(CREDIT_MAX + 1);
  localparam int RET_W_DEFAULT    = 2;

  typedef logic [CREDIT_W_DEFAULT-1:0] credit_t;

  typedef struct packed {
    logic overflow;
    logic ret_zero;
  } err_flags_t;
endpackage

// File: rtl/credit_counter_base.sv
// Saturating credit count register.
//   clk, reset      : clock, async active-low reset (count <- INIT_VAL)
//   max_count       : saturation ceiling
//   load            : reload INIT_VAL at next edge (wins over add/dec)
//   add_valid/count : credits added this cycle
//   dec             : one credit spent this cycle (caller guarantees count>0)
//   count           : registered count
//   count_next      : value count takes at next edge
//   sat             : this cycle's sum exceeded max_count and was clipped
module credit_counter_base #(
  parameter int                      CREDIT_WIDTH = 4,
  parameter int                      RET_WIDTH    = 2,
  parameter logic [CREDIT_WIDTH-1:0] INIT_VAL     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CREDIT_WIDTH-1:0] max_count,
  input  logic                    load,
  input  logic                    add_valid,
  input  logic [RET_WIDTH-1:0]    add_count,
  input  logic                    dec,
  output logic [CREDIT_WIDTH-1:0] count,
  output logic [CREDIT_WIDTH-1:0] count_next,
  output logic                    sat
);
  // One extra bit over the wider operand so credit+return never wraps.
  localparam int SW = ((CREDIT_WIDTH > RET_WIDTH) ? CREDIT_WIDTH : RET_WIDTH) + 1;

  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic [SW-1:0]           sum;

  always_comb begin
    sum     = SW'(count_q) + (add_valid ? SW'(add_count) : '0) - SW'(dec);
    sat     = 1'b0;
    count_d = sum[CREDIT_WIDTH-1:0];
    if (load) begin
      count_d = INIT_VAL;
    end else if (sum > SW'(max_count)) begin
      sat     = 1'b1;
      count_d = max_count;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= INIT_VAL;
    else        count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;
endmodule

// File: rtl/credit_counter.sv
// Sender-side credit tracker: grants sends while credit is available,
// absorbs multi-credit returns with saturation, raises sticky error flags.
//   clk, reset           : clock, async active-low reset
//   i__req / o__grant    : send request / combinational grant
//   i__ret_valid/_count  : credits returned by the receiver
//   i__reinit            : reload INIT_CREDIT, drop same-cycle return, block grant
//   i__err_clear         : clear sticky flags (a same-cycle new error wins)
//   o__credit(_next)     : registered count and its next-edge value
//   o__empty / o__full   : count==0 / count==NUM_CREDIT
//   o__err_overflow      : a return pushed credit past NUM_CREDIT
//   o__err_ret_zero      : return valid with zero count
module credit_counter
  import credit_pkg::*;
#(
  parameter int NUM_CREDIT   = CREDIT_MAX,
  parameter int CREDIT_WIDTH = $clog2(NUM_CREDIT + 1),
  parameter int INIT_CREDIT  = NUM_CREDIT,
  parameter int RET_WIDTH    = RET_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i__req,
  output logic                    o__grant,
  input  logic                    i__ret_valid,
  input  logic [RET_WIDTH-1:0]    i__ret_count,
  input  logic                    i__reinit,
  input  logic                    i__err_clear,
  output logic [CREDIT_WIDTH-1:0] o__credit,
  output logic [CREDIT_WIDTH-1:0] o__credit__next,
  output logic                    o__empty,
  output logic                    o__full,
  output logic                    o__err_overflow,
  output logic                    o__err_ret_zero
);
  logic [CREDIT_WIDTH-1:0] credit;
  logic                    grant, ret_valid_eff, sat, ret_zero_evt;
  err_flags_t              err_q, err_d;

  // Grant uses the registered count only, so a same-cycle return at zero
  // cannot enable it. Reset is an input here so the grant is masked while
  // reset is held regardless of the count.
  assign grant         = reset && i__req && (credit != '0) && !i__reinit;
  assign ret_valid_eff = i__ret_valid && !i__reinit;
  assign ret_zero_evt  = ret_valid_eff && (i__ret_count == '0);

  credit_counter_base #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .RET_WIDTH    (RET_WIDTH),
    .INIT_VAL     (CREDIT_WIDTH'(INIT_CREDIT))
  ) u_base (
    .clk        (clk),
    .reset      (reset),
    .max_count  (CREDIT_WIDTH'(NUM_CREDIT)),
    .load       (i__reinit),
    .add_valid  (ret_valid_eff),
    .add_count  (i__ret_count),
    .dec        (grant),
    .count      (credit),
    .count_next (o__credit__next),
    .sat        (sat)
  );

  always_comb begin
    err_d          = err_q;
    err_d.overflow = (err_q.overflow && !i__err_clear) || sat;
    err_d.ret_zero = (err_q.ret_zero && !i__err_clear) || ret_zero_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign o__grant        = grant;
  assign o__credit       = credit;
  assign o__empty        = (credit == '0);
  assign o__full         = (credit == CREDIT_WIDTH'(NUM_CREDIT));
  assign o__err_overflow = err_q.overflow;
  assign o__err_ret_zero = err_q.ret_zero;
endmodule

// File: tb/tb_credit_counter.sv
// Scoreboard bench for credit_counter: a driver applies directed then random
// cycles, pushes the expected outputs from a spec-level model, and a monitor
// pops and compares on the falling edge.
module tb_credit_counter;
  localparam int NC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i__req = 1'b0, i__ret_valid = 1'b0, i__reinit = 1'b0, i__err_clear = 1'b0;
  logic [1:0] i__ret_count = '0;
  logic       o__grant, o__empty, o__full, o__err_overflow, o__err_ret_zero;
  logic [3:0] o__credit, o__credit__next;

  credit_counter dut (
    .clk(clk), .reset(reset), .i__req(i__req), .o__grant(o__grant),
    .i__ret_valid(i__ret_valid), .i__ret_count(i__ret_count),
    .i__reinit(i__reinit), .i__err_clear(i__err_clear),
    .o__credit(o__credit), .o__credit__next(o__credit__next),
    .o__empty(o__empty), .o__full(o__full),
    .o__err_overflow(o__err_overflow), .o__err_ret_zero(o__err_ret_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    grant;
    int    credit;
    int    cnext;
    bit    empty, full, ov, rz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // reference model state
  int m_credit = NC;
  bit m_ov = 0, m_rz = 0;

  task automatic chk(input string tag, input string nm, input int act, input int exp);
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s.%s got=%0d want=%0d t=%0t", tag, nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      chk(e.tag, "grant",  int'(o__grant),        int'(e.grant));
      chk(e.tag, "credit", int'(o__credit),       e.credit);
      chk(e.tag, "cnext",  int'(o__credit__next), e.cnext);
      chk(e.tag, "empty",  int'(o__empty),        int'(e.empty));
      chk(e.tag, "full",   int'(o__full),         int'(e.full));
      chk(e.tag, "ov",     int'(o__err_overflow), int'(e.ov));
      chk(e.tag, "rz",     int'(o__err_ret_zero), int'(e.rz));
    end
  end

  // One cycle: drive #1 after the rising edge (reset drops here too, i.e.
  // asynchronously between edges), predict, push, advance the model.
  task automatic cyc(input string tag, input bit req, input bit rv, input int rc,
                     input bit ri, input bit clr, input bit rst);
    exp_t e;
    bit   q, r, ri_l, clr_l, g;
    int   c, s, nxt;
    q = req; r = rv; c = rc; ri_l = ri; clr_l = clr;
    if (!rst) begin q = 0; r = 0; c = 0; ri_l = 0; clr_l = 0; end
    @(posedge clk);
    #1;
    reset = rst; i__req = q; i__ret_valid = r; i__ret_count = 2'(c);
    i__reinit = ri_l; i__err_clear = clr_l;
    e.tag = tag;
    if (!rst) begin
      m_credit = NC; m_ov = 0; m_rz = 0;
      e.grant = 0; e.credit = NC; e.cnext = NC; e.ov = 0; e.rz = 0;
      e.empty = 0; e.full = 1;
      sb.push_back(e);
    end else begin
      g = q && (m_credit > 0) && !ri_l;
      e.grant = g; e.credit = m_credit; e.ov = m_ov; e.rz = m_rz;
      e.empty = (m_credit == 0); e.full = (m_credit == NC);
      if (ri_l) begin
        nxt = NC;
        m_ov = m_ov && !clr_l;
        m_rz = m_rz && !clr_l;
      end else begin
        s = m_credit + (r ? c : 0) - (g ? 1 : 0);
        nxt = (s > NC) ? NC : s;
        m_ov = (m_ov && !clr_l) || (s > NC);
        m_rz = (m_rz && !clr_l) || (r && c == 0);
      end
      e.cnext = nxt;
      sb.push_back(e);
      m_credit = nxt;
    end
  endtask

  initial begin
    cyc("reset", 0, 0, 0, 0, 0, 0);
    // drain 8 credits with continuous requests, two extra starved cycles
    for (int i = 0; i < 10; i++) cyc("drain", 1, 0, 0, 0, 0, 1);
    cyc("ret_at_zero", 1, 1, 3, 0, 0, 1);   // no grant, credit -> 3
    cyc("resume", 1, 0, 0, 0, 0, 1);        // 3 -> 2
    cyc("to4", 0, 1, 2, 0, 0, 1);           // 2 -> 4
    cyc("grant_ret1", 1, 1, 1, 0, 0, 1);    // stays 4
    cyc("to7", 0, 1, 3, 0, 0, 1);           // 4 -> 7
    cyc("overflow", 0, 1, 3, 0, 0, 1);      // 7 -> 8, overflow flag
    cyc("sticky", 0, 0, 0, 0, 0, 1);
    cyc("err_clear", 0, 0, 0, 0, 1, 1);
    cyc("cleared", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc("to2", 1, 0, 0, 0, 0, 1);
    cyc("reinit", 1, 1, 2, 1, 0, 1);        // no grant, -> 8, no error
    cyc("after_reinit", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("to5", 1, 0, 0, 0, 0, 1);
    cyc("midreset", 0, 0, 0, 0, 0, 0);
    cyc("post_reset", 1, 0, 0, 0, 0, 1);
    cyc("ret_zero", 0, 1, 0, 0, 0, 1);
    cyc("rz_sticky", 1, 0, 0, 0, 0, 1);
    cyc("clr_vs_set", 0, 1, 0, 0, 1, 1);    // set wins over clear
    cyc("rz_kept", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 4) < 2),
          int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 49) != 0));
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain_queue got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/credit_counter.md
Name: credit_counter

Overview:
- Sender-side credit tracker for a credit-based flow-control link. It is the consuming end of the count interface: the receiver returns credits, and this block grants sends by spending them.
- Holds the available credit count, initialised to INIT_CREDIT.
- Combinationally grants send requests while credit > 0.
- Accepts multi-credit returns per cycle, saturates on overflow, and flags protocol errors with sticky bits.
- Sits between a scheduler/PIFO output stage and a downstream buffer that returns credits.

Parameters:
- NUM_CREDIT, 8, maximum credits (downstream buffer depth).
- CREDIT_WIDTH, $clog2(NUM_CREDIT+1), width of credit count; must represent 0..NUM_CREDIT.
- INIT_CREDIT, NUM_CREDIT, credit value loaded on reset and on i__reinit; must be <= NUM_CREDIT.
- RET_WIDTH, 2, width of per-cycle credit return count (0..2^RET_WIDTH-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i__req  input  1  send request for this cycle.
- o__grant  output  1  send granted; combinational, equals i__req && credit!=0 && !reinit_block.
- i__ret_valid  input  1  credit return valid.
- i__ret_count  input  RET_WIDTH  number of credits returned; ignored when i__ret_valid=0.
- i__reinit  input  1  synchronous reload of INIT_CREDIT.
- i__err_clear  input  1  clears sticky error flags.
- o__credit  output  CREDIT_WIDTH  current registered credit count.
- o__credit__next  output  CREDIT_WIDTH  value o__credit takes after the next edge.
- o__empty  output  1  o__credit==0.
- o__full  output  1  o__credit==NUM_CREDIT.
- o__err_overflow  output  1  sticky: a return pushed credit above NUM_CREDIT.
- o__err_ret_zero  output  1  sticky: i__ret_valid asserted with i__ret_count==0.

Behaviour:
- Reset (reset=0, async): o__credit=INIT_CREDIT, both error flags 0. o__empty/o__full follow from INIT_CREDIT; defaults give o__full=1, o__empty=0. o__grant=0 because i__req is don't-care during reset; the grant is masked while reset is asserted.
- Grant: zero-latency combinational. The credit decrement is visible on o__credit one cycle later. A grant is never issued at credit 0, so underflow cannot occur.
- Next-value arithmetic, computed in CREDIT_WIDTH+1 bits: sum = credit + (ret_valid ? ret_count : 0) - grant.
  - If sum > NUM_CREDIT: next = NUM_CREDIT and set o__err_overflow.
  - Otherwise: next = sum.
- Simultaneous grant and return of 1: net change 0.
- Grant at credit 0: impossible. A return at credit 0 does not enable a grant in the same cycle; the grant is based on the registered credit.
- i__reinit=1:
  - next = INIT_CREDIT.
  - o__grant forced 0 that cycle.
  - Any same-cycle return is discarded and sets no error.
  - Sticky flags are unaffected.
- i__err_clear=1: flags clear next cycle. If a new error occurs in the same cycle, set wins.
- o__err_ret_zero is set when i__ret_valid=1 and i__ret_count=0. The count is unchanged apart from the grant.
- o__credit__next always equals the value registered at the next edge, including the reinit and saturation cases.
- Reset asserted mid-operation: state returns immediately to reset values. Returns in flight are lost; the owner must reinit the peer.

Decomposition:
- Shared package credit_pkg holds:
  - the credit-count typedef sized from NUM_CREDIT;
  - localparam CREDIT_MAX = NUM_CREDIT;
  - an error-flag struct {overflow, ret_zero}.
- One sub-module, credit_counter_base: holds the count register, computes next with saturation, and takes max_count as an input.
- Top level adds grant gating, reinit masking, and the sticky error logic.

Test Plan:
- Reset with defaults, then hold i__req=1 for 10 cycles with no returns. Expect o__grant=1 for cycles 1-8 and 0 for cycles 9-10; o__credit steps 8→0; o__empty=1 from cycle 9.
- With credit=0, return 3 (ret_valid=1, ret_count=3) with i__req=1. Expect o__grant=0 that cycle; o__credit=3 next cycle; the grant then resumes.
- With credit=4, i__req=1 and return 1 in the same cycle. Expect o__grant=1; o__credit stays 4; o__credit__next=4.
- With credit=7, return 3 and no request. Expect o__credit=8, o__err_overflow=1 (sticky). Then pulse i__err_clear with no error; the flag is 0 next cycle.
- With credit=2, i__reinit=1, i__req=1 and return 2. Expect o__grant=0; o__credit=8 next cycle; no error flag set.
- Mid-stream with credit=5, drop reset asynchronously between edges. Expect o__credit=8 immediately, flags 0; after release, the grant resumes from 8.
- i__ret_valid=1 with ret_count=0. Expect o__err_ret_zero=1 and the count unchanged.
